// File: rtl/grey_stream_seq.sv
`timescale 1ns/1ps
// Frame sequencer: walks an interleaved RGB byte buffer and emits the
// VSYNC/HSYNC/EN/DATA stream consumed by the grey-scale datapath.
module grey_stream_seq #(
    parameter int LINE_BYTES = 600,
    parameter int LINES      = 132,
    parameter int FRAMES     = 1,
    parameter int HBLANK     = 3,
    parameter int VBLANK     = 3,
    parameter int ADDR_W     = 17
) (
    input  logic              clk_sys,
    input  logic              reset_sys,
    input  logic              start,
    input  logic              pause,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              OutVSYNC,
    output logic              OutHSYNC,
    output logic              OutEN,
    output logic [7:0]        OutData
);

    localparam int GAP_MAX = (VBLANK > HBLANK) ? VBLANK : HBLANK;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam int BYTE_W  = $clog2(LINE_BYTES);
    localparam int LINE_W  = $clog2(LINES + 1);
    localparam int FRAME_W = $clog2(FRAMES + 1);

    localparam logic [GAP_W-1:0]   VGAP_LAST  = GAP_W'(VBLANK - 1);
    localparam logic [GAP_W-1:0]   HGAP_LAST  = GAP_W'(HBLANK - 1);
    localparam logic [BYTE_W-1:0]  BYTE_LAST  = BYTE_W'(LINE_BYTES - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(LINES - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        VGAP,
        SYNC,
        SETUP,
        ACTIVE,
        HGAP,
        TSYNC,
        DONE
    } state_t;

    state_t              state;
    logic [GAP_W-1:0]    gapCnt;
    logic [BYTE_W-1:0]   byteCnt;
    logic [BYTE_W-1:0]   rdLeft;
    logic [LINE_W-1:0]   lineCnt;
    logic [FRAME_W-1:0]  frameCnt;
    logic [ADDR_W-1:0]   rdAddr;

    always_ff @(posedge clk_sys or negedge reset_sys) begin
        if (!reset_sys) begin
            state     <= IDLE;
            gapCnt    <= '0;
            byteCnt   <= '0;
            rdLeft    <= '0;
            lineCnt   <= '0;
            frameCnt  <= '0;
            rdAddr    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            OutVSYNC  <= 1'b0;
            OutHSYNC  <= 1'b0;
            OutEN     <= 1'b0;
            OutData   <= '0;
        end else begin
            OutVSYNC <= 1'b0;
            OutHSYNC <= 1'b0;
            OutEN    <= 1'b0;
            OutData  <= '0;
            done     <= 1'b0;

            // A line's reads run back-to-back from its sync cycle, so each
            // byte lands on mem_rd_data exactly one cycle before its OutEN.
            if (rdLeft != '0) begin
                mem_rd_en <= 1'b1;
                mem_addr  <= rdAddr;
                rdAddr    <= rdAddr + ADDR_W'(1);
                rdLeft    <= rdLeft - BYTE_W'(1);
            end else begin
                mem_rd_en <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= VGAP;
                        busy     <= 1'b1;
                        rdAddr   <= base_addr;
                        gapCnt   <= '0;
                        lineCnt  <= '0;
                        frameCnt <= '0;
                    end
                end
                VGAP: begin
                    if (gapCnt == VGAP_LAST) begin
                        state     <= SYNC;
                        OutHSYNC  <= 1'b1;
                        OutVSYNC  <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= rdAddr;
                        rdAddr    <= rdAddr + ADDR_W'(1);
                        rdLeft    <= BYTE_LAST;
                    end else begin
                        gapCnt <= gapCnt + GAP_W'(1);
                    end
                end
                SYNC: begin
                    state <= SETUP;
                end
                SETUP: begin
                    state   <= ACTIVE;
                    byteCnt <= '0;
                    OutEN   <= 1'b1;
                    OutData <= mem_rd_data;
                end
                ACTIVE: begin
                    if (byteCnt == BYTE_LAST) begin
                        state  <= HGAP;
                        gapCnt <= '0;
                    end else begin
                        byteCnt <= byteCnt + BYTE_W'(1);
                        OutEN   <= 1'b1;
                        OutData <= mem_rd_data;
                    end
                end
                HGAP: begin
                    if (gapCnt != HGAP_LAST) begin
                        gapCnt <= gapCnt + GAP_W'(1);
                    end else if (!pause) begin
                        if (lineCnt == LINE_LAST && frameCnt == FRAME_LAST) begin
                            state    <= TSYNC;
                            OutHSYNC <= 1'b1;
                            OutVSYNC <= 1'b1;
                        end else begin
                            state     <= SYNC;
                            OutHSYNC  <= 1'b1;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= rdAddr;
                            rdAddr    <= rdAddr + ADDR_W'(1);
                            rdLeft    <= BYTE_LAST;
                            if (lineCnt == LINE_LAST) begin
                                lineCnt  <= '0;
                                frameCnt <= frameCnt + FRAME_W'(1);
                                OutVSYNC <= 1'b1;
                            end else begin
                                lineCnt <= lineCnt + LINE_W'(1);
                            end
                        end
                    end
                end
                TSYNC: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grey_stream_seq.sv
`timescale 1ns/1ps
// Bench for grey_stream_seq: two configurations checked cycle by cycle
// against a timeline model built from the frame/line/byte rules.
module tb_grey_stream_seq;

    localparam int MAXC = 512;

    localparam int LB_A = 6, LN_A = 2, FR_A = 1, HB_A = 3, VB_A = 3;
    localparam int LB_B = 3, LN_B = 2, FR_B = 2, HB_B = 2, VB_B = 1;

    logic        clk_sys = 1'b0;
    logic        reset_sys = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [16:0] baseIn = '0;
    logic        sel = 1'b0;

    logic        startA, pauseA, startB, pauseB;
    logic        busyA, doneA, rdA, hA, vA, enA;
    logic [16:0] addrA;
    logic [7:0]  dataA;
    logic [7:0]  rdDataA = '0;
    logic        busyB, doneB, rdB, hB, vB, enB;
    logic [3:0]  addrB;
    logic [7:0]  dataB;
    logic [7:0]  rdDataB = '0;

    logic        gBusy, gDone, gRd, gH, gV, gEn;
    logic [16:0] gAddr;
    logic [7:0]  gData;

    int checks = 0;
    int failures = 0;

    bit          expH[MAXC];
    bit          expV[MAXC];
    bit          expEn[MAXC];
    bit          expRd[MAXC];
    bit          expBusy[MAXC];
    bit          expDone[MAXC];
    logic [7:0]  expData[MAXC];
    int          expAddr[MAXC];
    bit          pauseAt[MAXC];
    bit          xStart[MAXC];
    int          endCyc;
    int          curBase;

    always #5 clk_sys = ~clk_sys;

    assign startA = start & ~sel;
    assign pauseA = pause & ~sel;
    assign startB = start & sel;
    assign pauseB = pause & sel;

    grey_stream_seq #(
        .LINE_BYTES(LB_A), .LINES(LN_A), .FRAMES(FR_A),
        .HBLANK(HB_A), .VBLANK(VB_A), .ADDR_W(17)
    ) dutA (
        .clk_sys(clk_sys), .reset_sys(reset_sys),
        .start(startA), .pause(pauseA), .base_addr(baseIn),
        .busy(busyA), .done(doneA),
        .mem_rd_en(rdA), .mem_addr(addrA), .mem_rd_data(rdDataA),
        .OutVSYNC(vA), .OutHSYNC(hA), .OutEN(enA), .OutData(dataA)
    );

    grey_stream_seq #(
        .LINE_BYTES(LB_B), .LINES(LN_B), .FRAMES(FR_B),
        .HBLANK(HB_B), .VBLANK(VB_B), .ADDR_W(4)
    ) dutB (
        .clk_sys(clk_sys), .reset_sys(reset_sys),
        .start(startB), .pause(pauseB), .base_addr(baseIn[3:0]),
        .busy(busyB), .done(doneB),
        .mem_rd_en(rdB), .mem_addr(addrB), .mem_rd_data(rdDataB),
        .OutVSYNC(vB), .OutHSYNC(hB), .OutEN(enB), .OutData(dataB)
    );

    assign gBusy = sel ? busyB : busyA;
    assign gDone = sel ? doneB : doneA;
    assign gRd   = sel ? rdB : rdA;
    assign gH    = sel ? hB : hA;
    assign gV    = sel ? vB : vA;
    assign gEn   = sel ? enB : enA;
    assign gData = sel ? dataB : dataA;
    assign gAddr = sel ? {13'd0, addrB} : addrA;

    function automatic logic [7:0] memFn(input int s, input int a);
        int v;
        v = (s == 0) ? a : a * 7 + 3;
        return v[7:0];
    endfunction

    always @(posedge clk_sys) begin
        if (rdA) rdDataA <= memFn(0, int'(addrA));
        if (rdB) rdDataB <= memFn(1, int'(addrB));
    end

    task automatic chk(input string nm, input int k, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, k, got, exp);
        end
    endtask

    // Index k+1 holds the expectation for cycle k (cycle -1 = start cycle).
    task automatic buildModel(input int s, input int base);
        int lb, ln, fr, hb, vb, mask, t, g, a;
        lb = s ? LB_B : LB_A;
        ln = s ? LN_B : LN_A;
        fr = s ? FR_B : FR_A;
        hb = s ? HB_B : HB_A;
        vb = s ? VB_B : VB_A;
        mask = s ? 15 : 131071;
        for (int i = 0; i < MAXC; i++) begin
            expH[i] = 0; expV[i] = 0; expEn[i] = 0; expRd[i] = 0;
            expBusy[i] = 0; expDone[i] = 0; expData[i] = '0; expAddr[i] = 0;
        end
        a = base;
        t = vb;
        for (int f = 0; f < fr; f++) begin
            for (int j = 0; j < ln; j++) begin
                expH[t+1] = 1;
                expV[t+1] = (j == 0);
                for (int b = 0; b < lb; b++) begin
                    expRd[t+b+1]   = 1;
                    expAddr[t+b+1] = a & mask;
                    expEn[t+b+3]   = 1;
                    expData[t+b+3] = memFn(s, a & mask);
                    a++;
                end
                g = t + 2 + lb + hb - 1;
                while (g < MAXC - 100 && pauseAt[g]) g++;
                t = g + 1;
            end
        end
        expH[t+1] = 1;
        expV[t+1] = 1;
        for (int i = 0; i <= t; i++) expBusy[i+1] = 1;
        expDone[t+2] = 1;
        endCyc = t + 1;
    endtask

    task automatic prep(input int s, input int base, input int pm, input int em);
        sel = s[0];
        for (int k = 0; k < MAXC; k++) begin
            pauseAt[k] = 0;
            xStart[k] = 0;
        end
        if (pm == 1) begin
            for (int k = 11; k < 20; k++) pauseAt[k] = 1;
            pauseAt[7] = 1;
        end
        if (pm == 2)
            for (int k = 0; k < MAXC - 120; k++) pauseAt[k] = ($urandom_range(0, 3) == 0);
        if (em == 1) begin
            xStart[2] = 1;
            xStart[12] = 1;
        end
        if (em == 2)
            for (int k = 0; k < MAXC; k++) xStart[k] = ($urandom_range(0, 7) == 0);
        curBase = base;
        buildModel(s, base);
    endtask

    task automatic checkCycle(input int k);
        int i;
        i = k + 1;
        chk("busy", k, int'(gBusy), int'(expBusy[i]));
        chk("done", k, int'(gDone), int'(expDone[i]));
        chk("hsync", k, int'(gH), int'(expH[i]));
        chk("vsync", k, int'(gV), int'(expV[i]));
        chk("en", k, int'(gEn), int'(expEn[i]));
        chk("data", k, int'(gData), int'(expData[i]));
        chk("rd_en", k, int'(gRd), int'(expRd[i]));
        if (expRd[i]) chk("addr", k, int'(gAddr), expAddr[i]);
    endtask

    task automatic exec(input int stopAt);
        baseIn = 17'(curBase);
        start = 1'b1;
        pause = 1'b0;
        @(negedge clk_sys);
        checkCycle(-1);
        for (int k = 0; k <= endCyc; k++) begin
            @(posedge clk_sys);
            #1;
            start = xStart[k];
            pause = pauseAt[k];
            baseIn = 17'($urandom);
            @(negedge clk_sys);
            checkCycle(k);
            if (k == stopAt) return;
        end
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            checkCycle(-1);
            @(posedge clk_sys);
            #1;
        end
    endtask

    initial begin
        int nv, nh, nd;
        #1;
        sel = 1'b0;
        #1;
        checkCycle(-1);
        chk("rst_addrA", -1, int'(gAddr), 0);
        sel = 1'b1;
        #1;
        checkCycle(-1);
        chk("rst_addrB", -1, int'(gAddr), 0);
        @(posedge clk_sys);
        #1;
        reset_sys = 1'b1;
        sel = 1'b0;
        idle(2);

        prep(0, 0, 0, 1);
        chk("pin_h3", 3, int'(expH[4]), 1);
        chk("pin_v3", 3, int'(expV[4]), 1);
        chk("pin_h14", 14, int'(expH[15]), 1);
        chk("pin_v14", 14, int'(expV[15]), 0);
        chk("pin_en5", 5, int'(expEn[6]), 1);
        chk("pin_d10", 10, int'(expData[11]), 5);
        chk("pin_d16", 16, int'(expData[17]), 6);
        chk("pin_rd19", 19, int'(expRd[20]), 1);
        chk("pin_rd20", 20, int'(expRd[21]), 0);
        chk("pin_t25", 25, int'(expV[26]), 1);
        chk("pin_done", 26, endCyc, 26);
        exec(-1);
        prep(0, 0, 0, 0);
        exec(-1);
        idle(3);

        prep(0, 0, 1, 0);
        chk("pin_p_h21", 21, int'(expH[22]), 1);
        chk("pin_p_en28", 28, int'(expEn[29]), 1);
        chk("pin_p_done", 33, endCyc, 33);
        exec(-1);
        idle(1);

        prep(0, 131070, 2, 2);
        exec(-1);
        repeat (6) begin
            prep(0, int'($urandom_range(0, 131071)), 2, 2);
            exec(-1);
            idle(int'($urandom_range(0, 2)));
        end

        prep(1, 14, 0, 0);
        chk("pin_a0", 1, expAddr[2], 14);
        chk("pin_a1", 2, expAddr[3], 15);
        chk("pin_a2", 3, expAddr[4], 0);
        chk("pin_d14", 3, int'(expData[4]), 101);
        nv = 0; nh = 0; nd = 0;
        for (int i = 0; i < MAXC; i++) begin
            nv += int'(expV[i]);
            nh += int'(expH[i]);
            nd += int'(expDone[i]);
        end
        chk("pin_nv", -1, nv, 3);
        chk("pin_nh", -1, nh, 5);
        chk("pin_nd", -1, nd, 1);
        exec(-1);
        repeat (6) begin
            prep(1, int'($urandom_range(0, 15)), 2, 2);
            exec(-1);
            idle(int'($urandom_range(0, 2)));
        end
        idle(1);

        prep(0, int'($urandom_range(0, 1000)), 0, 0);
        exec(7);
        #2;
        reset_sys = 1'b0;
        #1;
        checkCycle(-1);
        chk("rst_mid_addr", 7, int'(gAddr), 0);
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        pause = 1'b0;
        idle(2);
        reset_sys = 1'b1;
        idle(20);

        prep(0, 5, 2, 2);
        exec(-1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
